// File: rtl/clk_en_manager.sv
// Multi-channel clock-enable generator on clkin with lock qualification.
// Each channel counts down a programmable divide; rstn_lock flags that all channels are aligned.
module clk_en_manager #(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned DEFAULT_DIV = 6,
  parameter int unsigned LOCK_CYCLES = 16,
  parameter int unsigned SYNC_STAGES = 2,
  localparam int unsigned CHAN_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clkin,
  input  logic                rst,
  input  logic                lock_in,
  input  logic                align_req,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CHAN_W-1:0]   cfg_chan,
  input  logic [CNT_W-1:0]    cfg_div,
  input  logic [CNT_W-1:0]    cfg_phase,
  output logic [CHANNELS-1:0] ce_out,
  output logic [CHANNELS-1:0] clk_div_out,
  output logic                rstn_lock
);

  localparam int unsigned LockW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [LockW-1:0] LockMax = LockW'(LOCK_CYCLES - 1);

  typedef enum logic [1:0] {StWaitLock = 2'd0, StAlign = 2'd1, StRun = 2'd2} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [LockW-1:0]       lock_cnt_q, lock_cnt_d;
  logic                   lock_s;
  logic                   cfg_fire;
  logic [CNT_W-1:0]       cfg_div_c, cfg_phase_c;

  assign lock_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      sync_q     <= '0;
      lock_cnt_q <= '0;
      state_q    <= StWaitLock;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], lock_in};
      lock_cnt_q <= lock_cnt_d;
      state_q    <= state_d;
    end
  end

  always_comb begin
    lock_cnt_d = '0;
    if (lock_s) lock_cnt_d = (lock_cnt_q == LockMax) ? lock_cnt_q : lock_cnt_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StWaitLock: if (lock_s && lock_cnt_q == LockMax) state_d = StAlign;
      StAlign:    state_d = lock_s ? StRun : StWaitLock;
      StRun: begin
        // Lock loss takes priority over a re-align request.
        if (!lock_s)        state_d = StWaitLock;
        else if (align_req) state_d = StAlign;
      end
      default:    state_d = StWaitLock;
    endcase
  end

  always_comb begin
    rstn_lock = (state_q == StRun);
    cfg_ready = ~rst && (state_q != StAlign);
  end

  assign cfg_fire = cfg_valid && cfg_ready;

  always_comb begin
    cfg_div_c   = (cfg_div == '0) ? CNT_W'(1) : cfg_div;
    cfg_phase_c = (cfg_phase >= cfg_div_c) ? '0 : cfg_phase;
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    logic [CNT_W-1:0] cnt_q, cnt_d, div_q, div_d, shadow_q, shadow_d, phase_q, phase_d;
    logic             ce_q, ce_d, cd_q, cd_d, wr;

    // Out-of-range channel indices match no channel, so such writes are dropped.
    assign wr = cfg_fire && (cfg_chan == CHAN_W'(i));

    always_comb begin
      cnt_d    = cnt_q;
      div_d    = div_q;
      shadow_d = shadow_q;
      phase_d  = phase_q;
      if (wr) begin
        shadow_d = cfg_div_c;
        phase_d  = cfg_phase_c;
        if (state_q == StWaitLock) div_d = cfg_div_c;
      end
      unique case (state_q)
        StAlign: cnt_d = (phase_q < div_q) ? div_q - CNT_W'(1) - phase_q : div_q - CNT_W'(1);
        StRun: begin
          if (cnt_q == '0) begin
            cnt_d = shadow_q - CNT_W'(1);
            div_d = shadow_q;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: ;
      endcase
      ce_d = (state_d == StRun) && (cnt_d == '0);
      cd_d = (state_d == StRun) && (div_d >= CNT_W'(2)) && (cnt_d >= (div_d >> 1));
    end

    always_ff @(posedge clkin or posedge rst) begin
      if (rst) begin
        cnt_q    <= '0;
        div_q    <= CNT_W'(DEFAULT_DIV);
        shadow_q <= CNT_W'(DEFAULT_DIV);
        phase_q  <= '0;
        ce_q     <= 1'b0;
        cd_q     <= 1'b0;
      end else begin
        cnt_q    <= cnt_d;
        div_q    <= div_d;
        shadow_q <= shadow_d;
        phase_q  <= phase_d;
        ce_q     <= ce_d;
        cd_q     <= cd_d;
      end
    end

    assign ce_out[i]      = ce_q;
    assign clk_div_out[i] = cd_q;
  end

endmodule

// File: tb/tb_clk_en_manager.sv
// Directed bench for clk_en_manager: expected per-cycle outputs are queued ahead of the stimulus
// and popped/compared one cycle at a time.
module tb_clk_en_manager;

  localparam int CH = 4;

  logic       clkin = 1'b0;
  logic       rst = 1'b1;
  logic       lock_in = 1'b0;
  logic       align_req = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [1:0] cfg_chan = '0;
  logic [7:0] cfg_div = '0;
  logic [7:0] cfg_phase = '0;
  logic [3:0] ce_out, clk_div_out;
  logic       rstn_lock;

  typedef struct {
    string      tag;
    logic [3:0] ce;
    logic [3:0] cd;
    logic       rstn;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail = 0;
  // Per-channel divide and a RUN-cycle index at which that channel's ce is known to fire.
  int   bd[CH];
  int   ba[CH];

  clk_en_manager dut (
    .clkin      (clkin),
    .rst        (rst),
    .lock_in    (lock_in),
    .align_req  (align_req),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_chan   (cfg_chan),
    .cfg_div    (cfg_div),
    .cfg_phase  (cfg_phase),
    .ce_out     (ce_out),
    .clk_div_out(clk_div_out),
    .rstn_lock  (rstn_lock)
  );

  always #5 clkin = ~clkin;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input string tag, input int t);
    exp_t e;
    e.tag  = $sformatf("%s[%0d]", tag, t);
    e.rstn = 1'b1;
    for (int i = 0; i < CH; i++) begin
      int r;
      r = ((ba[i] - t) % bd[i] + bd[i]) % bd[i];
      e.ce[i] = (r == 0);
      e.cd[i] = (bd[i] >= 2) && (r >= bd[i] / 2);
    end
    return e;
  endfunction

  task automatic push_run(input string tag, input int t0, input int n);
    for (int k = 0; k < n; k++) sb.push_back(mk(tag, t0 + k));
  endtask

  task automatic push_idle(input string tag, input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.tag  = $sformatf("%s[%0d]", tag, k);
      e.ce   = '0;
      e.cd   = '0;
      e.rstn = 1'b0;
      sb.push_back(e);
    end
  endtask

  task automatic cyc();
    exp_t e;
    @(posedge clkin);
    #1;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL sb_underflow: observed empty queue, required an expected entry");
    end else begin
      e = sb.pop_front();
      check({e.tag, "_ce"}, 32'(ce_out), 32'(e.ce));
      check({e.tag, "_cd"}, 32'(clk_div_out), 32'(e.cd));
      check({e.tag, "_rstn"}, 32'(rstn_lock), 32'(e.rstn));
    end
  endtask

  task automatic cfg_write(input int ch, input int d, input int p);
    cfg_valid = 1'b1;
    cfg_chan  = 2'(ch);
    cfg_div   = 8'(d);
    cfg_phase = 8'(p);
  endtask

  initial begin
    bd = '{6, 6, 6, 6};
    ba = '{5, 5, 5, 5};
    repeat (3) @(posedge clkin);
    #1;
    check("rst_cfg_ready", 32'(cfg_ready), 0);
    check("rst_rstn", 32'(rstn_lock), 0);
    check("rst_ce", 32'(ce_out), 0);
    check("rst_cd", 32'(clk_div_out), 0);

    // Lock from edge 0; configure channels while waiting for lock.
    rst = 1'b0;
    lock_in = 1'b1;
    #1 check("wait_cfg_ready", 32'(cfg_ready), 1);
    push_idle("lock_wait", 18);
    cfg_write(2, 6, 2); cyc();
    cfg_write(3, 0, 5); cyc();  // div 0 -> 1, phase -> 0
    cfg_write(0, 3, 7); cyc();  // phase >= div -> 0
    cfg_valid = 1'b0;
    repeat (14) cyc();
    cyc();
    check("align_cfg_ready", 32'(cfg_ready), 0);

    bd = '{3, 6, 6, 1};
    ba = '{2, 5, 3, 0};
    push_run("run1", 0, 24);
    repeat (24) cyc();

    // Mid-period divide change on ch1: old period completes at t=29, then period 4.
    push_run("div_mid_a", 24, 6);
    bd[1] = 4; ba[1] = 33;
    push_run("div_mid_b", 30, 12);
    cyc();
    cfg_write(1, 4, 0); cyc();
    cfg_valid = 1'b0;
    repeat (16) cyc();

    // Write coincident with terminal count at t=45: one more 4-period before 6 applies.
    push_run("div_tc_a", 42, 8);
    bd[1] = 6; ba[1] = 55;
    push_run("div_tc_b", 50, 12);
    repeat (4) cyc();
    cfg_write(1, 6, 0); cyc();
    cfg_valid = 1'b0;
    repeat (15) cyc();

    // Phase change on ch2 only takes effect through align_req.
    push_run("pre_align", 62, 1);
    push_idle("align", 1);
    cfg_write(2, 6, 0); cyc();
    cfg_valid = 1'b0;
    align_req = 1'b1; cyc();
    check("align_cfg_ready2", 32'(cfg_ready), 0);
    align_req = 1'b0;
    ba = '{2, 5, 5, 0};
    push_run("realign", 0, 12);
    repeat (12) cyc();

    // Lock loss in RUN, then relock with a one-cycle glitch after 10 high cycles.
    push_run("loss_run", 12, 2);
    push_idle("relock", 31);
    push_run("relocked", 0, 12);
    lock_in = 1'b0; repeat (4) cyc();
    lock_in = 1'b1; repeat (10) cyc();
    lock_in = 1'b0; cyc();
    lock_in = 1'b1; repeat (18) cyc();
    repeat (12) cyc();

    // align_req in the same cycle as synchronized lock loss must land in WAIT_LOCK.
    push_run("loss2_run", 12, 2);
    push_idle("loss2", 19);
    push_run("post", 0, 3);
    lock_in = 1'b0; cyc(); cyc();
    align_req = 1'b1; cyc();
    check("loss_beats_align_ready", 32'(cfg_ready), 1);
    align_req = 1'b0;
    lock_in = 1'b1;
    repeat (18) cyc();
    repeat (3) cyc();

    // Async reset mid-RUN clears outputs without a clock edge.
    #2 rst = 1'b1;
    #1;
    check("arst_ce", 32'(ce_out), 0);
    check("arst_cd", 32'(clk_div_out), 0);
    check("arst_rstn", 32'(rstn_lock), 0);
    check("arst_cfg_ready", 32'(cfg_ready), 0);
    check("sb_drained", 32'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
